// File: rtl/bits_detector_pkg.sv
// Shared constants and FSM state encoding for the bits detector
// controller; also reused by encoder-side benches.
package bits_detector_pkg;

   localparam int BANKS      = 4;
   localparam int BANK_W     = $clog2(BANKS);
   localparam int PRE_LEN    = 6;
   localparam logic [PRE_LEN-1:0] PREAMBLE = 6'b101011;
   localparam int DWELL      = 64;
   localparam int FLUSH_STRB = 2;
   localparam int GAP_MAX    = 48;
   localparam int NBITS_W    = 8;

   localparam int FLUSH_W = $clog2(FLUSH_STRB) + 1;
   localparam int DWELL_W = $clog2(DWELL) + 1;
   localparam int GAP_W   = $clog2(GAP_MAX) + 1;
   localparam int PAY_W   = NBITS_W + 1;

   typedef enum logic [2:0] {
      IDLE,
      FLUSH,
      SEARCH,
      PAYLOAD,
      DONE,
      FAIL
   } state_t;

endpackage

// File: rtl/bits_detector_ctrl_if.sv
// Control/data bundle between the environment, the detector
// and the bits detector controller.
interface bits_detector_ctrl_if;
   import bits_detector_pkg::*;

   logic               start;
   logic [NBITS_W-1:0] num_bits;
   logic               in_vld;
   logic               det_dat;
   logic               det_vld;
   logic               det_rst;
   logic [BANK_W-1:0]  frequency_bank;
   logic               out_dat;
   logic               out_vld;
   logic               out_last;
   logic               busy;
   logic               locked;
   logic               done;
   logic               fail;

   modport master (
      output start, num_bits, in_vld, det_dat, det_vld,
      input  det_rst, frequency_bank, out_dat, out_vld,
      input  out_last, busy, locked, done, fail
   );

   modport slave (
      input  start, num_bits, in_vld, det_dat, det_vld,
      output det_rst, frequency_bank, out_dat, out_vld,
      output out_last, busy, locked, done, fail
   );

endinterface

// File: rtl/preamble_matcher.sv
// Preamble search: LSB-in shift register with a match
// evaluated on the value the register is about to take.
module preamble_matcher
   import bits_detector_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic shift_en,
   input  logic din,
   output logic match
);

   logic [PRE_LEN-1:0] sr;
   logic [PRE_LEN-1:0] sr_nxt;

   assign sr_nxt = {sr[PRE_LEN-2:0], din};
   assign match  = shift_en && (sr_nxt == PREAMBLE);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         sr <= '0;
      end else if (shift_en) begin
         sr <= sr_nxt;
      end
   end

endmodule

// File: rtl/bits_detector_ctrl.sv
// Sweeps detector banks looking for the preamble, then forwards
// num_bits payload bits from the locked bank.
module bits_detector_ctrl
   import bits_detector_pkg::*;
(
   input logic           clk,
   input logic           rst,
   bits_detector_ctrl_if.slave bus
);

   state_t state;
   state_t state_nxt;

   logic [NBITS_W-1:0] nb;
   logic [BANK_W-1:0]  bank;
   logic [FLUSH_W-1:0] flush_cnt;
   logic [DWELL_W-1:0] dwell_cnt;
   logic [GAP_W-1:0]   gap_cnt;
   logic [PAY_W-1:0]   pay_cnt;
   logic [PAY_W-1:0]   nb_m1;
   logic dat_q, vld_q, last_q;
   logic accept, flush_end, shift_en, match;
   logic dwell_end, last_bank, take_bit, last_bit, gap_end;

   assign accept    = state == IDLE && bus.start;
   assign flush_end = state == FLUSH && bus.in_vld &&
                      flush_cnt == FLUSH_W'(FLUSH_STRB - 1);
   assign shift_en  = state == SEARCH && bus.det_vld;
   assign dwell_end = state == SEARCH && bus.in_vld &&
                      dwell_cnt == DWELL_W'(DWELL - 1);
   assign last_bank = bank == BANK_W'(BANKS - 1);
   assign take_bit  = state == PAYLOAD && bus.det_vld;
   assign nb_m1     = PAY_W'(nb) - PAY_W'(1);
   assign last_bit  = take_bit && pay_cnt == nb_m1;
   // A bit arriving on the expiry strobe keeps the lock alive
   assign gap_end   = state == PAYLOAD && !bus.det_vld &&
                      bus.in_vld && gap_cnt == GAP_W'(GAP_MAX - 1);

   preamble_matcher u_match (
      .clk      (clk),
      .rst      (rst),
      .clr      (flush_end),
      .shift_en (shift_en),
      .din      (bus.det_dat),
      .match    (match)
   );

   always_comb begin
      state_nxt   = state;
      bus.det_rst = 1'b1;
      bus.busy    = 1'b0;
      bus.locked  = 1'b0;
      bus.done    = 1'b0;
      bus.fail    = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) state_nxt = FLUSH;
         end
         FLUSH: begin
            bus.busy = 1'b1;
            if (flush_end) state_nxt = SEARCH;
         end
         SEARCH: begin
            bus.det_rst = 1'b0;
            bus.busy    = 1'b1;
            if (match) state_nxt = (nb == '0) ? DONE : PAYLOAD;
            else if (dwell_end) state_nxt = last_bank ? FAIL : FLUSH;
         end
         PAYLOAD: begin
            bus.det_rst = 1'b0;
            bus.busy    = 1'b1;
            bus.locked  = 1'b1;
            if (last_bit) state_nxt = DONE;
            else if (gap_end) state_nxt = FAIL;
         end
         DONE: begin
            bus.done  = 1'b1;
            state_nxt = IDLE;
         end
         FAIL: begin
            bus.fail  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         nb        <= '0;
         bank      <= '0;
         flush_cnt <= '0;
         dwell_cnt <= '0;
         gap_cnt   <= '0;
         pay_cnt   <= '0;
         dat_q     <= 1'b0;
         vld_q     <= 1'b0;
         last_q    <= 1'b0;
      end else begin
         state  <= state_nxt;
         vld_q  <= take_bit;
         dat_q  <= take_bit & bus.det_dat;
         last_q <= last_bit;
         if (accept) begin
            nb   <= bus.num_bits;
            bank <= '0;
         end
         if (state == FLUSH && bus.in_vld)
            flush_cnt <= flush_end ? '0 : flush_cnt + FLUSH_W'(1);
         if (flush_end)
            dwell_cnt <= '0;
         else if (state == SEARCH && bus.in_vld)
            dwell_cnt <= dwell_cnt + DWELL_W'(1);
         if (dwell_end && !match && !last_bank)
            bank <= bank + BANK_W'(1);
         if (match) begin
            pay_cnt <= '0;
            gap_cnt <= '0;
         end else if (take_bit) begin
            pay_cnt <= pay_cnt + PAY_W'(1);
            gap_cnt <= '0;
         end else if (state == PAYLOAD && bus.in_vld) begin
            gap_cnt <= gap_cnt + GAP_W'(1);
         end
      end
   end

   assign bus.frequency_bank = bank;
   assign bus.out_dat        = dat_q;
   assign bus.out_vld        = vld_q;
   assign bus.out_last       = last_q;

endmodule

// File: doc/bits_detector_ctrl.md
Name: bits_detector_ctrl

Overview:
Sequences one bits_detector instance for a single tag reply. On start it sweeps frequency_bank across all BANKS, holding each bank for a fixed dwell and searching the decoded bit stream for the preamble. On a match it locks the bank, forwards exactly num_bits payload bits with a last flag, and reports done or fail. It sits between the sample front-end (in_vld strobe) and the bit sink. It owns the detector's rst and frequency_bank inputs.

Parameters:
BANKS, 4, number of frequency banks; BANK_W = $clog2(BANKS)
PRE_LEN, 6, preamble length in bits
PREAMBLE, 6'b101011, preamble pattern, MSB received first
DWELL, 64, in_vld strobes spent per bank before advancing
FLUSH_STRB, 2, in_vld strobes det_rst is held per flush
GAP_MAX, 48, in_vld strobes allowed between det_vld pulses in PAYLOAD
NBITS_W, 8, width of num_bits

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle request; ignored while busy
num_bits  in  NBITS_W  payload length, sampled on accepted start
in_vld  in  1  sample strobe (same strobe feeding the detector)
det_dat  in  1  detector out_dat
det_vld  in  1  detector out_vld
det_rst  out  1  detector reset
frequency_bank  out  BANK_W  detector bank select
out_dat  out  1  payload bit
out_vld  out  1  payload bit valid
out_last  out  1  with out_vld on final payload bit
busy  out  1  high from accepted start until done/fail
locked  out  1  high in PAYLOAD
done  out  1  one-cycle pulse, success
fail  out  1  one-cycle pulse, no lock or gap timeout

Behaviour:
- Reset values: state IDLE; det_rst=1; frequency_bank=0; out_dat=0; out_vld=0; out_last=0; busy=0; locked=0; done=0; fail=0; all counters and the shift register are 0.
- IDLE: det_rst=1. Accepted start (start=1 in IDLE) latches num_bits, sets bank=0 and moves to FLUSH. busy rises the next cycle.
- FLUSH: det_rst=1. Count in_vld strobes. On the FLUSH_STRB-th strobe, clear the shift register and dwell counter and go to SEARCH.
- SEARCH: det_rst=0. On every det_vld, shift det_dat into a PRE_LEN-bit register (LSB in). A match is combinational on the post-shift value equalling PREAMBLE. The dwell counter increments on in_vld.
  - On a match: go to PAYLOAD with the bank held, and clear the payload and gap counters.
  - Else, when dwell reaches DWELL-1 with in_vld set: if bank < BANKS-1, increment bank and go to FLUSH; otherwise go to FAIL.
  - A match and dwell expiry in the same cycle resolve as a match.
- PAYLOAD: locked=1. Each det_vld produces out_dat=det_dat and out_vld=1, registered with 1-cycle latency.
  - The payload counter increments on each bit. out_last=1 on bit num_bits-1, followed by DONE.
  - The gap counter clears on det_vld and increments on in_vld without det_vld. Reaching GAP_MAX goes to FAIL; any partially emitted payload is not retracted.
  - det_vld and gap expiry in the same cycle: the bit wins and the gap counter clears.
  - num_bits=0: PAYLOAD is skipped and the match goes directly to DONE with no out_vld.
- DONE: done=1 for one cycle, then IDLE. frequency_bank keeps the locked value until the next accepted start.
- FAIL: fail=1 for one cycle, then IDLE. frequency_bank stays at the last bank tried.
- det_vld outside SEARCH/PAYLOAD is ignored. start outside IDLE is ignored, including the DONE/FAIL cycle.
- Counter widths: $clog2 of their limits plus 1. No wrap occurs, because every terminal compare forces a state change.
- rst asserted mid-operation returns to IDLE next edge with reset values. No done or fail is issued.

Decomposition:
- Package bits_detector_pkg holds the state enum (IDLE, FLUSH, SEARCH, PAYLOAD, DONE, FAIL) and the shared PREAMBLE/PRE_LEN constants, so the encoder-side bench can reuse them.
- One natural sub-module is preamble_matcher: the PRE_LEN shift register plus compare, with clr and shift_en inputs and a match output.
- The FSM and counters stay in the top module.

Test Plan:
- Bank 0 lock: reset, start with num_bits=16, FM0 stream at bank 0 carrying preamble plus 16 bits -> frequency_bank=0, exactly 16 out_vld matching the sent bits, out_last on the 16th, then a done pulse.
- Sweep to bank 2: stream decodes only at bank 2 -> bank sequence 0,1,2 with det_rst high for 2 strobes before each bank; lock at bank 2; done; frequency_bank stays 2 in IDLE.
- No reply: constant-zero input -> 4×(2+64) strobes elapse, then a fail pulse and zero out_vld.
- Gap timeout: lock, 5 bits delivered, then det_vld stops -> fail after 48 in_vld strobes, exactly 5 out_vld, no out_last.
- Edge cases:
  - num_bits=0 -> done one cycle after the match, no out_vld.
  - Match coinciding with the final dwell strobe -> lock, not advance.
  - start while busy -> ignored.
- Mid-reply reset: assert rst during PAYLOAD after 3 bits -> next cycle in IDLE, det_rst=1, busy=0, no done/fail pulse; a subsequent start runs normally.
